aes_ctr_issuer: RTL and testbench
=================================

# aes_ctr_issuer

Request-side sequencer for the AES-GCM datapath: drives the enable/ready/valid handshake of the AES control unit from the initiator end. Per message it forms GCM counter blocks from a 96-bit IV, submits J0 (tag-mask block) then inc32 keystream counters one at a time, and buffers returned ciphertext blocks in a small keystream FIFO for the GCTR XOR stage. Sits between the GCM top-level control and the AES core.

## Interface
- FIFO_DEPTH, 4, keystream buffer depth in 128-bit entries (power of 2, ≥2)
- CNT_W, 16, width of block-count input

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_iv  in  96  IV, captured on accepted i_start
- i_ctr0  in  32  initial counter word of J0, captured on accepted i_start
- i_num_blocks  in  CNT_W  keystream blocks to produce, captured on accepted i_start (0 legal)
- o_aes_en  out  1  request to AES core
- o_aes_block  out  128  counter block presented with o_aes_en
- i_aes_ready  in  1  AES core can accept a request this cycle
- i_aes_valid  in  1  one-cycle pulse, i_aes_result valid
- i_aes_result  in  128  encrypted block
- o_tag_mask  out  128  E(K,J0), held until next accepted start
- o_tag_mask_valid  out  1  high from J0 result until next accepted start
- o_ks_valid  out  1  FIFO non-empty
- o_ks_data  out  128  FIFO head
- i_ks_ready  in  1  downstream pop; pop occurs when o_ks_valid && i_ks_ready
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of message

## Operation
- States: IDLE, TAG_REQ, TAG_WAIT, KS_REQ, KS_WAIT, DRAIN.
- IDLE: i_start captures IV, ctr=i_ctr0, remaining=i_num_blocks; clears o_tag_mask_valid; -> TAG_REQ.
- TAG_REQ: o_aes_en=1, o_aes_block={iv,ctr}; on i_aes_ready -> TAG_WAIT, ctr<=ctr+1.
- TAG_WAIT: on i_aes_valid load o_tag_mask, set o_tag_mask_valid; -> KS_REQ if remaining≠0, else DRAIN.
- KS_REQ: o_aes_en=1 only when fifo_count < FIFO_DEPTH (outstanding result counts against space; at most one outstanding, so no overflow possible). On accept: remaining--, ctr++ -> KS_WAIT.
- KS_WAIT: on i_aes_valid push result; -> KS_REQ if remaining≠0 else DRAIN.
- DRAIN: when FIFO empty (including same-cycle last pop) -> o_done pulse next cycle, -> IDLE.
- inc32: ctr increments mod 2^32; upper 96 bits never change. 32'hFFFFFFFF -> 32'h00000000.
- i_start outside IDLE ignored. i_aes_valid outside *_WAIT ignored (no push, no state change).
- FIFO simultaneous push and pop: both take effect, count unchanged.
- o_aes_block driven {iv,ctr} at all times; only meaningful with o_aes_en.

## Timing
- Reset values: o_aes_en=0, o_aes_block=0, o_tag_mask=0, o_tag_mask_valid=0, o_ks_valid=0, o_ks_data=0 (empty FIFO), o_busy=0, o_done=0; state IDLE, counters 0.
- o_aes_en, o_busy combinational from state/count; o_done registered.
- i_start at edge N -> o_busy and o_aes_en high after edge N.
- Request accepted in the cycle o_aes_en && i_aes_ready; next request no earlier than cycle after i_aes_valid.
- FIFO push at edge with i_aes_valid; o_ks_valid high the following cycle (1-cycle write-to-read latency).
- rst asserted mid-message: all state cleared immediately; outstanding AES result after release ignored (arrives in IDLE).

## Structure
- Shared package aes_gcm_pkg: block width (128), IV width (96), counter width (32), state enum, inc32 function.
- One sub-module: aes_ks_fifo (synchronous FIFO, parameter DEPTH, 128-bit, count output, show-ahead head).

## Test plan
- IV=96'h cafebabefacedbaddecaf888, ctr0=1, num=3, AES model returns block XOR all-ones, ready always, valid 2 cycles after accept -> requests ctr 1,2,3,4 in order; tag_mask=~{iv,32'd1}; 3 FIFO entries in order; one o_done pulse.
- num=0 -> only J0 request, tag_mask valid, no o_ks_valid, o_done after TAG_WAIT.
- ctr0=32'hFFFFFFFE, num=3 -> request counter words FFFFFFFE, FFFFFFFF, 00000000, 00000001; IV bits unchanged.
- FIFO_DEPTH=4, num=8, i_ks_ready=0 -> exactly 4 keystream requests then o_aes_en low; raise i_ks_ready -> remaining 4 issued, 8 blocks in order, no loss/duplication.
- i_aes_ready low 5 cycles in TAG_REQ -> o_aes_en held, o_aes_block stable; i_start pulses while busy ignored.
- rst asserted during KS_WAIT with 2 FIFO entries -> all outputs at reset values same cycle; late i_aes_valid after release causes no push; new start runs cleanly.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM request path: block/IV/counter widths,
// issuer state encoding and the GCM inc32 counter step.
package aes_gcm_pkg;

  localparam int BLOCK_W = 128;
  localparam int IV_W    = 96;
  localparam int CTR_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG_REQ,
    ST_TAG_WAIT,
    ST_KS_REQ,
    ST_KS_WAIT,
    ST_DRAIN
  } gcm_state_t;

  // Only the low 32-bit word steps; it wraps FFFFFFFF -> 00000000.
  function automatic logic [CTR_W-1:0] inc32(input logic [CTR_W-1:0] ctr);
    return ctr + 32'd1;
  endfunction

endpackage

// File: rtl/aes_ks_fifo.sv
// Keystream buffer: synchronous show-ahead FIFO of 128-bit blocks with an
// occupancy count; the head reads as zero while empty.
module aes_ks_fifo
  import aes_gcm_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [BLOCK_W-1:0] push_data,
  input  logic               pop,
  output logic [CW-1:0]      count,
  output logic               head_valid,
  output logic [BLOCK_W-1:0] head_data
);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               do_push;
  logic               do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign head_data  = (cnt != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/aes_ctr_issuer.sv
// GCM counter-block issuer: sends J0 then inc32 keystream counters to the AES
// core one at a time and queues the returned keystream for the GCTR stage.
module aes_ctr_issuer
  import aes_gcm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [IV_W-1:0]    i_iv,
  input  logic [CTR_W-1:0]   i_ctr0,
  input  logic [CNT_W-1:0]   i_num_blocks,
  output logic               o_aes_en,
  output logic [BLOCK_W-1:0] o_aes_block,
  input  logic               i_aes_ready,
  input  logic               i_aes_valid,
  input  logic [BLOCK_W-1:0] i_aes_result,
  output logic [BLOCK_W-1:0] o_tag_mask,
  output logic               o_tag_mask_valid,
  output logic               o_ks_valid,
  output logic [BLOCK_W-1:0] o_ks_data,
  input  logic               i_ks_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  gcm_state_t         state;
  gcm_state_t         state_nx;
  logic [IV_W-1:0]    iv_q;
  logic [CTR_W-1:0]   ctr_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [BLOCK_W-1:0] tag_mask_q;
  logic               tag_mask_valid_q;
  logic               done_q;
  logic [FCW-1:0]     fifo_count;
  logic               aes_en;
  logic               accept;
  logic               push;
  logic               pop;
  logic               tag_load;
  logic               start_ok;

  assign accept   = aes_en && i_aes_ready;
  assign pop      = o_ks_valid && i_ks_ready;
  assign start_ok = (state == ST_IDLE) && i_start;

  // The single outstanding request is budgeted against FIFO space, so a
  // keystream request is held back until a slot is guaranteed.
  always_comb begin
    state_nx = state;
    aes_en   = 1'b0;
    push     = 1'b0;
    tag_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nx = ST_TAG_REQ;
      end
      ST_TAG_REQ: begin
        aes_en = 1'b1;
        if (i_aes_ready) state_nx = ST_TAG_WAIT;
      end
      ST_TAG_WAIT: begin
        if (i_aes_valid) begin
          tag_load = 1'b1;
          state_nx = (remaining_q != '0) ? ST_KS_REQ : ST_DRAIN;
        end
      end
      ST_KS_REQ: begin
        aes_en = (fifo_count < FCW'(FIFO_DEPTH));
        if (accept) state_nx = ST_KS_WAIT;
      end
      ST_KS_WAIT: begin
        if (i_aes_valid) begin
          push     = 1'b1;
          state_nx = (remaining_q != '0) ? ST_KS_REQ : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop))
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      iv_q             <= '0;
      ctr_q            <= '0;
      remaining_q      <= '0;
      tag_mask_q       <= '0;
      tag_mask_valid_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == ST_DRAIN) && (state_nx == ST_IDLE);
      if (start_ok) begin
        iv_q             <= i_iv;
        ctr_q            <= i_ctr0;
        remaining_q      <= i_num_blocks;
        tag_mask_valid_q <= 1'b0;
      end
      if (accept) begin
        ctr_q <= inc32(ctr_q);
        if (state == ST_KS_REQ) remaining_q <= remaining_q - CNT_W'(1);
      end
      if (tag_load) begin
        tag_mask_q       <= i_aes_result;
        tag_mask_valid_q <= 1'b1;
      end
    end
  end

  aes_ks_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (i_aes_result),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(o_ks_valid),
    .head_data (o_ks_data)
  );

  assign o_aes_en         = aes_en;
  assign o_aes_block      = {iv_q, ctr_q};
  assign o_tag_mask       = tag_mask_q;
  assign o_tag_mask_valid = tag_mask_valid_q;
  assign o_busy           = (state != ST_IDLE);
  assign o_done           = done_q;

endmodule

// File: tb/tb_aes_ctr_issuer.sv
// Directed bench for aes_ctr_issuer with a behavioural AES core that answers
// each accepted request with the bitwise inverse of the block.
module tb_aes_ctr_issuer;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_start = 1'b0;
  logic [95:0]        i_iv = '0;
  logic [31:0]        i_ctr0 = '0;
  logic [CNT_W-1:0]   i_num_blocks = '0;
  logic               o_aes_en;
  logic [127:0]       o_aes_block;
  logic               i_aes_ready = 1'b1;
  logic               i_aes_valid = 1'b0;
  logic [127:0]       i_aes_result = '0;
  logic [127:0]       o_tag_mask;
  logic               o_tag_mask_valid;
  logic               o_ks_valid;
  logic [127:0]       o_ks_data;
  logic               i_ks_ready = 1'b1;
  logic               o_busy;
  logic               o_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] req_log[$];
  logic [127:0] popped[$];
  int           done_cnt     = 0;
  int           ks_valid_seen = 0;
  int           lat          = 2;
  int           pend_cnt     = 0;
  logic [127:0] pend_block   = '0;

  aes_ctr_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_iv            (i_iv),
    .i_ctr0          (i_ctr0),
    .i_num_blocks    (i_num_blocks),
    .o_aes_en        (o_aes_en),
    .o_aes_block     (o_aes_block),
    .i_aes_ready     (i_aes_ready),
    .i_aes_valid     (i_aes_valid),
    .i_aes_result    (i_aes_result),
    .o_tag_mask      (o_tag_mask),
    .o_tag_mask_valid(o_tag_mask_valid),
    .o_ks_valid      (o_ks_valid),
    .o_ks_data       (o_ks_data),
    .i_ks_ready      (i_ks_ready),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  // AES core model and monitors, evaluated mid-cycle; a handshake seen here
  // takes effect at the following rising edge.
  always @(negedge clk) begin
    i_aes_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        i_aes_valid  = 1'b1;
        i_aes_result = ~pend_block;
      end
    end
    if (o_aes_en && i_aes_ready) begin
      req_log.push_back(o_aes_block);
      pend_block = o_aes_block;
      pend_cnt   = lat;
    end
    if (o_ks_valid && i_ks_ready) popped.push_back(o_ks_data);
    if (o_done) done_cnt++;
    if (o_ks_valid) ks_valid_seen++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [95:0] iv, input logic [31:0] ctr0,
                               input logic [CNT_W-1:0] num);
    @(posedge clk); #1;
    i_iv         = iv;
    i_ctr0       = ctr0;
    i_num_blocks = num;
    i_start      = 1'b1;
    @(posedge clk); #1;
    i_start      = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    checkOutput(tag, 128'(seen), 128'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic waitReqs(input string tag, input int n, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (req_log.size() >= n) seen = 1'b1;
    end
    checkOutput(tag, 128'(seen), 128'd1);
  endtask

  task automatic clearLogs();
    req_log.delete();
    popped.delete();
    done_cnt      = 0;
    ks_valid_seen = 0;
  endtask

  function automatic logic [127:0] reqAt(input int i);
    return (i < req_log.size()) ? req_log[i] : 128'bx;
  endfunction

  function automatic logic [127:0] popAt(input int i);
    return (i < popped.size()) ? popped[i] : 128'bx;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_en"},    128'(o_aes_en), 128'd0);
    checkOutput({tag, "_block"}, o_aes_block, 128'd0);
    checkOutput({tag, "_tag"},   o_tag_mask, 128'd0);
    checkOutput({tag, "_tagv"},  128'(o_tag_mask_valid), 128'd0);
    checkOutput({tag, "_ksv"},   128'(o_ks_valid), 128'd0);
    checkOutput({tag, "_ksd"},   o_ks_data, 128'd0);
    checkOutput({tag, "_busy"},  128'(o_busy), 128'd0);
    checkOutput({tag, "_done"},  128'(o_done), 128'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [95:0] iv1, iv2, iv3, iv4, iv5, iv6, iv7;
    logic [31:0] w3 [4];
    iv1 = 96'hcafebabefacedbaddecaf888;
    iv2 = 96'h0123456789abcdef00112233;
    iv3 = 96'h00000000ffffffff12345678;
    iv4 = 96'hdeadbeef0000111122223333;
    iv5 = 96'h5a5a5a5aa5a5a5a5c3c3c3c3;
    iv6 = 96'h111111112222222233333333;
    iv7 = 96'h0f0e0d0c0b0a090807060504;
    w3  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic message: J0 then three keystream counters
    clearLogs();
    applyStimulus(iv1, 32'd1, 16'd3);
    @(negedge clk);
    checkOutput("t1_busy", 128'(o_busy), 128'd1);
    checkOutput("t1_en", 128'(o_aes_en), 128'd1);
    waitDone("t1_done", 200);
    checkOutput("t1_nreq", 128'(req_log.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("t1_req", reqAt(i), {iv1, 32'(i + 1)});
    checkOutput("t1_tag", o_tag_mask, ~{iv1, 32'd1});
    checkOutput("t1_tagv", 128'(o_tag_mask_valid), 128'd1);
    checkOutput("t1_npop", 128'(popped.size()), 128'd3);
    for (int i = 0; i < 3; i++)
      checkOutput("t1_ks", popAt(i), ~{iv1, 32'(i + 2)});
    checkOutput("t1_ndone", 128'(done_cnt), 128'd1);
    checkOutput("t1_idle", 128'(o_busy), 128'd0);

    // Zero keystream blocks: only the tag-mask request
    clearLogs();
    applyStimulus(iv2, 32'h10, 16'd0);
    waitDone("t2_done", 100);
    checkOutput("t2_nreq", 128'(req_log.size()), 128'd1);
    checkOutput("t2_req", reqAt(0), {iv2, 32'h10});
    checkOutput("t2_tag", o_tag_mask, ~{iv2, 32'h10});
    checkOutput("t2_tagv", 128'(o_tag_mask_valid), 128'd1);
    checkOutput("t2_ksv", 128'(ks_valid_seen), 128'd0);
    checkOutput("t2_ndone", 128'(done_cnt), 128'd1);

    // inc32 wraps in the low word only
    clearLogs();
    applyStimulus(iv3, 32'hFFFFFFFE, 16'd3);
    waitDone("t3_done", 200);
    checkOutput("t3_nreq", 128'(req_log.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("t3_req", reqAt(i), {iv3, w3[i]});
    for (int i = 0; i < 3; i++)
      checkOutput("t3_ks", popAt(i), ~{iv3, w3[i + 1]});

    // Backpressure: FIFO fills to depth and requests stop
    clearLogs();
    i_ks_ready = 1'b0;
    applyStimulus(iv4, 32'h100, 16'd8);
    waitReqs("t4_fill", 5, 200);
    repeat (30) @(negedge clk);
    checkOutput("t4_nreq_full", 128'(req_log.size()), 128'd5);
    checkOutput("t4_en_full", 128'(o_aes_en), 128'd0);
    checkOutput("t4_ksv_full", 128'(o_ks_valid), 128'd1);
    checkOutput("t4_busy_full", 128'(o_busy), 128'd1);
    @(posedge clk); #1;
    i_ks_ready = 1'b1;
    waitDone("t4_done", 400);
    checkOutput("t4_nreq", 128'(req_log.size()), 128'd9);
    checkOutput("t4_npop", 128'(popped.size()), 128'd8);
    for (int i = 0; i < 8; i++)
      checkOutput("t4_ks", popAt(i), ~{iv4, 32'(32'h101 + i)});
    checkOutput("t4_ndone", 128'(done_cnt), 128'd1);

    // AES not ready in TAG_REQ; stray start while busy
    clearLogs();
    i_aes_ready = 1'b0;
    applyStimulus(iv5, 32'h55, 16'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t5_en_held", 128'(o_aes_en), 128'd1);
      checkOutput("t5_block_stable", o_aes_block, {iv5, 32'h55});
      if (k == 1) begin
        @(posedge clk); #1;
        i_start = 1'b1;
        i_iv    = ~iv5;
        @(posedge clk); #1;
        i_start = 1'b0;
      end
    end
    @(posedge clk); #1;
    i_aes_ready = 1'b1;
    waitDone("t5_done", 200);
    checkOutput("t5_nreq", 128'(req_log.size()), 128'd2);
    checkOutput("t5_req0", reqAt(0), {iv5, 32'h55});
    checkOutput("t5_req1", reqAt(1), {iv5, 32'h56});
    checkOutput("t5_ks", popAt(0), ~{iv5, 32'h56});
    checkOutput("t5_ndone", 128'(done_cnt), 128'd1);

    // Reset mid-message with two buffered blocks and one outstanding result
    clearLogs();
    lat        = 6;
    i_ks_ready = 1'b0;
    applyStimulus(iv6, 32'h20, 16'd4);
    waitReqs("t6_third_req", 4, 300);
    @(posedge clk); #1;
    checkOutput("t6_pre_busy", 128'(o_busy), 128'd1);
    checkOutput("t6_pre_ksv", 128'(o_ks_valid), 128'd1);
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_rst");
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t6_late_ksv", 128'(o_ks_valid), 128'd0);
    checkOutput("t6_late_busy", 128'(o_busy), 128'd0);
    checkOutput("t6_late_tagv", 128'(o_tag_mask_valid), 128'd0);
    checkOutput("t6_late_tag", o_tag_mask, 128'd0);

    clearLogs();
    lat        = 2;
    i_ks_ready = 1'b1;
    applyStimulus(iv7, 32'h7, 16'd2);
    waitDone("t7_done", 200);
    checkOutput("t7_nreq", 128'(req_log.size()), 128'd3);
    checkOutput("t7_tag", o_tag_mask, ~{iv7, 32'h7});
    checkOutput("t7_npop", 128'(popped.size()), 128'd2);
    checkOutput("t7_ks0", popAt(0), ~{iv7, 32'h8});
    checkOutput("t7_ks1", popAt(1), ~{iv7, 32'h9});
    checkOutput("t7_ndone", 128'(done_cnt), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
